// File: rtl/ldm_stm_sequencer.sv
// Block-transfer sequencer for LDM/STM: walks reg_list in ascending order,
// issuing one memory request per set bit and writing loads back one cycle later.
module ldm_stm_sequencer #(
    parameter int unsigned NREGS     = 15,
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_is_load,
    input  logic [31:0]      i_base_addr,
    input  logic [NREGS-1:0] i_reg_list,
    output logic             o_busy,
    output logic             o_done,
    output logic [31:0]      o_end_addr,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic [31:0]      o_mem_addr,
    output logic [31:0]      o_mem_wdata,
    input  logic             i_mem_ack,
    input  logic [31:0]      i_mem_rdata,
    output logic [3:0]       o_rf_src,
    input  logic [31:0]      i_rf_data,
    output logic             o_wb_en,
    output logic [3:0]       o_wb_dest,
    output logic [31:0]      o_wb_result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [NREGS-1:0] LIST_ONE = NREGS'(1);
    localparam logic [31:0]      STEP     = 32'(ADDR_STEP);

    state_t           r_state;
    logic [NREGS-1:0] r_list;
    logic             r_is_load;
    logic             r_busy;
    logic             r_done;
    logic [31:0]      r_end_addr;
    logic             r_mem_req;
    logic             r_mem_we;
    logic [31:0]      r_mem_addr;
    logic [3:0]       r_rf_src;
    logic             r_wb_en;
    logic [3:0]       r_wb_dest;
    logic [31:0]      r_wb_result;

    logic [NREGS-1:0] w_next_list;
    logic [31:0]      w_end_addr;

    // Index of the lowest set bit (0 when empty).
    function automatic logic [3:0] f_lowest(input logic [NREGS-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int k = int'(NREGS) - 1; k >= 0; k--) begin
            if (v[k]) idx = 4'(k);
        end
        return idx;
    endfunction

    // Number of set bits.
    function automatic logic [31:0] f_popcount(input logic [NREGS-1:0] v);
        logic [31:0] n;
        n = '0;
        for (int k = 0; k < int'(NREGS); k++) begin
            n = n + 32'(v[k]);
        end
        return n;
    endfunction

    // Remaining list after retiring the current (lowest) bit, and final address.
    assign w_next_list = r_list & (r_list - LIST_ONE);
    assign w_end_addr  = i_base_addr + STEP * f_popcount(i_reg_list);

    // Sequencer FSM; all outputs except store data are registered here.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_list      <= '0;
            r_is_load   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_end_addr  <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_rf_src    <= '0;
            r_wb_en     <= 1'b0;
            r_wb_dest   <= '0;
            r_wb_result <= '0;
        end else begin
            r_wb_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_is_load  <= i_is_load;
                        r_list     <= i_reg_list;
                        r_end_addr <= w_end_addr;
                        r_busy     <= 1'b1;
                        r_mem_addr <= i_base_addr;
                        r_rf_src   <= f_lowest(i_reg_list);
                        if (i_reg_list == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= S_REQ;
                            r_mem_req <= 1'b1;
                            r_mem_we  <= ~i_is_load;
                        end
                    end
                end
                S_REQ: begin
                    if (i_mem_ack) begin
                        if (r_is_load) begin
                            r_wb_en     <= 1'b1;
                            r_wb_dest   <= r_rf_src;
                            r_wb_result <= i_mem_rdata;
                        end
                        r_list <= w_next_list;
                        if (w_next_list != '0) begin
                            r_mem_addr <= r_mem_addr + STEP;
                            r_rf_src   <= f_lowest(w_next_list);
                        end else begin
                            r_state   <= S_DONE;
                            r_mem_req <= 1'b0;
                            r_mem_we  <= 1'b0;
                            r_done    <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_done    <= 1'b0;
                    r_busy    <= 1'b0;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Store data follows the register file directly while an STM request is up.
    assign o_mem_wdata = (r_state == S_REQ && !r_is_load) ? i_rf_data : '0;

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_end_addr  = r_end_addr;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_rf_src    = r_rf_src;
    assign o_wb_en     = r_wb_en;
    assign o_wb_dest   = r_wb_dest;
    assign o_wb_result = r_wb_result;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed self-checking bench for ldm_stm_sequencer.
module tb_ldm_stm_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_load;
    logic [31:0] base_addr;
    logic [14:0] reg_list;
    logic        busy, done, mem_req, mem_we, mem_ack, wb_en;
    logic [31:0] end_addr, mem_addr, mem_wdata, mem_rdata, rf_data, wb_result;
    logic [3:0]  rf_src, wb_dest;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Register file model: Rk reads as 0xDEAD0000 + k.
    assign rf_data = 32'hDEAD0000 | {28'h0, rf_src};

    ldm_stm_sequencer dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_is_load(is_load),
        .i_base_addr(base_addr), .i_reg_list(reg_list), .o_busy(busy), .o_done(done),
        .o_end_addr(end_addr), .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
        .o_rf_src(rf_src), .i_rf_data(rf_data), .o_wb_en(wb_en), .o_wb_dest(wb_dest),
        .o_wb_result(wb_result)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; is_load = 1'b0; base_addr = '0; reg_list = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        tick(); tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0b exp=0", done); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0b exp=0", mem_req); end
        total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL rst_wb got=%0b exp=0", wb_en); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", mem_addr); end
        total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", mem_wdata); end
        total++; if (end_addr !== 32'h0) begin bad++; $display("FAIL rst_end got=%h exp=0", end_addr); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_stm_basic();
        start = 1'b1; is_load = 1'b0; base_addr = 32'h100; reg_list = 15'h0005; mem_ack = 1'b1;
        tick(); start = 1'b0;
        total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL stm_req0 got req=%0b we=%0b busy=%0b exp=1/1/1", mem_req, mem_we, busy); end
        total++; if (mem_addr !== 32'h100 || rf_src !== 4'd0) begin bad++; $display("FAIL stm_addr0 got=%h/%0d exp=100/0", mem_addr, rf_src); end
        total++; if (mem_wdata !== 32'hDEAD0000) begin bad++; $display("FAIL stm_wdata0 got=%h exp=DEAD0000", mem_wdata); end
        total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL stm_wb0 got=%0b exp=0", wb_en); end
        tick();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h104 || rf_src !== 4'd2) begin bad++; $display("FAIL stm_addr1 got req=%0b %h/%0d exp=1 104/2", mem_req, mem_addr, rf_src); end
        total++; if (mem_wdata !== 32'hDEAD0002) begin bad++; $display("FAIL stm_wdata1 got=%h exp=DEAD0002", mem_wdata); end
        total++; if (wb_en !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL stm_mid got wb=%0b done=%0b exp=0/0", wb_en, done); end
        tick();
        total++; if (done !== 1'b1 || busy !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL stm_done got done=%0b busy=%0b req=%0b exp=1/1/0", done, busy, mem_req); end
        total++; if (end_addr !== 32'h108 || wb_en !== 1'b0) begin bad++; $display("FAIL stm_end got=%h wb=%0b exp=108/0", end_addr, wb_en); end
        total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL stm_wdata_idle got=%h exp=0", mem_wdata); end
        tick(); mem_ack = 1'b0;
        total++; if (done !== 1'b0 || busy !== 1'b0 || wb_en !== 1'b0) begin bad++; $display("FAIL stm_idle got done=%0b busy=%0b wb=%0b exp=0/0/0", done, busy, wb_en); end
        total++; if (end_addr !== 32'h108) begin bad++; $display("FAIL stm_end_hold got=%h exp=108", end_addr); end
    endtask

    task automatic test_ldm_wait();
        start = 1'b1; is_load = 1'b1; base_addr = 32'h200; reg_list = 15'h4001; mem_ack = 1'b0;
        tick(); start = 1'b0;
        total++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h200 || rf_src !== 4'd0) begin bad++; $display("FAIL ldm_req0 got req=%0b we=%0b %h/%0d exp=1 0 200/0", mem_req, mem_we, mem_addr, rf_src); end
        total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL ldm_wdata got=%h exp=0", mem_wdata); end
        tick();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h200 || wb_en !== 1'b0) begin bad++; $display("FAIL ldm_wait1 got req=%0b %h wb=%0b exp=1 200 0", mem_req, mem_addr, wb_en); end
        tick();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin bad++; $display("FAIL ldm_wait2 got req=%0b %h exp=1 200", mem_req, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'hAAAA0000;
        tick(); mem_ack = 1'b0; mem_rdata = 32'h12345678;
        total++; if (wb_en !== 1'b1 || wb_dest !== 4'd0 || wb_result !== 32'hAAAA0000) begin bad++; $display("FAIL ldm_wb0 got en=%0b d=%0d r=%h exp=1 0 AAAA0000", wb_en, wb_dest, wb_result); end
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h204 || rf_src !== 4'd14) begin bad++; $display("FAIL ldm_req1 got req=%0b %h/%0d exp=1 204/14", mem_req, mem_addr, rf_src); end
        tick();
        total++; if (wb_en !== 1'b0 || mem_addr !== 32'h204) begin bad++; $display("FAIL ldm_wbpulse got en=%0b %h exp=0 204", wb_en, mem_addr); end
        tick();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h204 || done !== 1'b0) begin bad++; $display("FAIL ldm_wait3 got req=%0b %h done=%0b exp=1 204 0", mem_req, mem_addr, done); end
        mem_ack = 1'b1; mem_rdata = 32'hBBBB0000;
        tick(); mem_ack = 1'b0; mem_rdata = '0;
        total++; if (done !== 1'b1 || mem_req !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL ldm_done got done=%0b req=%0b busy=%0b exp=1/0/1", done, mem_req, busy); end
        total++; if (wb_en !== 1'b1 || wb_dest !== 4'd14 || wb_result !== 32'hBBBB0000) begin bad++; $display("FAIL ldm_wb1 got en=%0b d=%0d r=%h exp=1 14 BBBB0000", wb_en, wb_dest, wb_result); end
        total++; if (end_addr !== 32'h208) begin bad++; $display("FAIL ldm_end got=%h exp=208", end_addr); end
        tick();
        total++; if (wb_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL ldm_idle got wb=%0b done=%0b busy=%0b exp=0/0/0", wb_en, done, busy); end
    endtask

    task automatic test_zero_list();
        start = 1'b1; is_load = 1'b0; base_addr = 32'h300; reg_list = 15'h0; mem_ack = 1'b0;
        tick(); start = 1'b0;
        total++; if (mem_req !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL zero_done got req=%0b done=%0b busy=%0b exp=0/1/1", mem_req, done, busy); end
        total++; if (end_addr !== 32'h300) begin bad++; $display("FAIL zero_end got=%h exp=300", end_addr); end
        tick();
        total++; if (done !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL zero_idle got done=%0b busy=%0b req=%0b exp=0/0/0", done, busy, mem_req); end
    endtask

    task automatic test_start_ignored();
        start = 1'b1; is_load = 1'b0; base_addr = 32'h400; reg_list = 15'h0003; mem_ack = 1'b0;
        tick();
        base_addr = 32'h900; reg_list = 15'h7FFF; is_load = 1'b1;
        tick();
        total++; if (mem_addr !== 32'h400 || rf_src !== 4'd0 || mem_we !== 1'b1) begin bad++; $display("FAIL ign_req0 got %h/%0d we=%0b exp=400/0 1", mem_addr, rf_src, mem_we); end
        mem_ack = 1'b1;
        tick();
        total++; if (mem_addr !== 32'h404 || rf_src !== 4'd1 || mem_req !== 1'b1) begin bad++; $display("FAIL ign_req1 got %h/%0d req=%0b exp=404/1 1", mem_addr, rf_src, mem_req); end
        total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL ign_wb got=%0b exp=0", wb_en); end
        tick();
        total++; if (done !== 1'b1 || mem_req !== 1'b0 || end_addr !== 32'h408) begin bad++; $display("FAIL ign_done got done=%0b req=%0b end=%h exp=1 0 408", done, mem_req, end_addr); end
        tick(); start = 1'b0; mem_ack = 1'b0;
        total++; if (busy !== 1'b0 || mem_req !== 1'b0 || done !== 1'b0 || end_addr !== 32'h408) begin bad++; $display("FAIL ign_idle got busy=%0b req=%0b done=%0b end=%h exp=0 0 0 408", busy, mem_req, done, end_addr); end
        tick();
    endtask

    task automatic test_reset_mid();
        start = 1'b1; is_load = 1'b1; base_addr = 32'h500; reg_list = 15'h0007;
        mem_ack = 1'b1; mem_rdata = 32'h11111111;
        tick(); start = 1'b0;
        tick();
        total++; if (wb_en !== 1'b1 || wb_dest !== 4'd0 || mem_addr !== 32'h504) begin bad++; $display("FAIL mid_wb0 got en=%0b d=%0d %h exp=1 0 504", wb_en, wb_dest, mem_addr); end
        mem_ack = 1'b0; reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || mem_req !== 1'b0 || wb_en !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mid_rst_ctl got busy=%0b req=%0b wb=%0b done=%0b exp=0", busy, mem_req, wb_en, done); end
        total++; if (mem_addr !== 32'h0 || end_addr !== 32'h0 || wb_result !== 32'h0) begin bad++; $display("FAIL mid_rst_data got %h %h %h exp=0", mem_addr, end_addr, wb_result); end
        total++; if (rf_src !== 4'd0 || wb_dest !== 4'd0 || mem_we !== 1'b0) begin bad++; $display("FAIL mid_rst_idx got %0d %0d we=%0b exp=0", rf_src, wb_dest, mem_we); end
        tick(); tick();
        reset = 1'b0; mem_ack = 1'b1;
        tick();
        total++; if (wb_en !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_post got wb=%0b req=%0b busy=%0b exp=0", wb_en, mem_req, busy); end
        start = 1'b1; is_load = 1'b0; base_addr = 32'h600; reg_list = 15'h0002;
        tick(); start = 1'b0;
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h600 || rf_src !== 4'd1 || mem_we !== 1'b1) begin bad++; $display("FAIL mid_new got req=%0b %h/%0d we=%0b exp=1 600/1 1", mem_req, mem_addr, rf_src, mem_we); end
        tick();
        total++; if (done !== 1'b1 || end_addr !== 32'h604 || wb_en !== 1'b0) begin bad++; $display("FAIL mid_new_done got done=%0b %h wb=%0b exp=1 604 0", done, end_addr, wb_en); end
        tick(); mem_ack = 1'b0;
    endtask

    task automatic test_wrap();
        start = 1'b1; is_load = 1'b0; base_addr = 32'hFFFFFFFC; reg_list = 15'h0003; mem_ack = 1'b1;
        tick(); start = 1'b0;
        total++; if (mem_addr !== 32'hFFFFFFFC) begin bad++; $display("FAIL wrap_a0 got=%h exp=FFFFFFFC", mem_addr); end
        tick();
        total++; if (mem_addr !== 32'h0 || mem_req !== 1'b1) begin bad++; $display("FAIL wrap_a1 got=%h req=%0b exp=0 1", mem_addr, mem_req); end
        tick();
        total++; if (done !== 1'b1 || end_addr !== 32'h4) begin bad++; $display("FAIL wrap_end got done=%0b %h exp=1 4", done, end_addr); end
        tick(); mem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stm_basic();
        test_ldm_wait();
        test_zero_list();
        test_start_ignored();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ldm_stm_sequencer.md
LDM_STM_SEQUENCER -- requirements
Module: ldm_stm_sequencer

Interface
REQ-001 Parameter NREGS, default 15: number of architectural registers covered by reg_list (R0..R14).
REQ-002 Parameter ADDR_STEP, default 4: byte increment between consecutive transfers.
REQ-003 clk  input  1  rising-edge clock for all sequencer state.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  begin a block transfer; sampled only in IDLE.
REQ-006 is_load  input  1  1 = LDM (memory to registers), 0 = STM (registers to memory); latched at start.
REQ-007 base_addr  input  32  first transfer address; latched at start.
REQ-008 reg_list  input  15  bit k set = register Rk transferred; latched at start.
REQ-009 busy  output  1  high from the cycle after start acceptance through the DONE cycle.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 end_addr  output  32  base_addr + ADDR_STEP*popcount(reg_list); valid at done; held until next accepted start.
REQ-012 mem_req  output  1  memory request, held until mem_ack.
REQ-013 mem_we  output  1  1 for STM requests, 0 for LDM.
REQ-014 mem_addr  output  32  current transfer address.
REQ-015 mem_wdata  output  32  store data (STM).
REQ-016 mem_ack  input  1  memory accepts/completes current request this cycle.
REQ-017 mem_rdata  input  32  load data, valid when mem_ack=1 on LDM.
REQ-018 rf_src  output  4  register-file read index (STM source).
REQ-019 rf_data  input  32  register-file read data for rf_src (combinational).
REQ-020 wb_en  output  1  register write-back enable (LDM).
REQ-021 wb_dest  output  4  write-back register index.
REQ-022 wb_result  output  32  write-back data.

Function
REQ-023 States SHALL be IDLE, REQ, DONE; IDLE -> REQ on start with nonzero reg_list; IDLE -> DONE on start with reg_list=0; REQ -> REQ on mem_ack with bits remaining; REQ -> DONE on mem_ack for last bit; DONE -> IDLE unconditionally.
REQ-024 start in REQ or DONE SHALL be ignored with no effect on latched operands.
REQ-025 Registers SHALL be transferred in ascending index order; the k-th transfer (k from 0) SHALL use mem_addr = base_addr + ADDR_STEP*k, 32-bit wrap-around on overflow.
REQ-026 In REQ, mem_req=1 and mem_addr, mem_we, rf_src, mem_wdata SHALL stay stable until the cycle mem_ack=1; rf_src = lowest remaining set index.
REQ-027 mem_wdata SHALL equal rf_data combinationally during STM, and 0 otherwise.
REQ-028 On a mem_ack rising-edge sample, the current bit SHALL be cleared; the next transfer SHALL present mem_req=1 in the immediately following cycle (back-to-back, no idle gap).
REQ-029 For LDM, the cycle after each mem_ack SHALL have wb_en=1, wb_dest = acked index, wb_result = mem_rdata captured at ack; wb_en SHALL be a single-cycle pulse per transfer; STM SHALL never assert wb_en.
REQ-030 The last LDM write-back SHALL coincide with the DONE cycle.
REQ-031 DONE SHALL last exactly one cycle with done=1, busy=1, mem_req=0.
REQ-032 mem_ack while mem_req=0 SHALL be ignored.

Reset
REQ-033 reset SHALL force IDLE immediately, including mid-transfer, with busy, done, mem_req, mem_we, wb_en = 0, mem_addr, mem_wdata, rf_src, wb_dest, wb_result, end_addr = 0; no pending write-back SHALL survive reset.
REQ-034 After reset release, the first accepted start SHALL behave identically to one from a fresh power-up.

Verification
REQ-035 STM reg_list=0x0005, base=0x100, ack held 1 -> writes R0 @0x100, R2 @0x104 on consecutive cycles; done next cycle; end_addr=0x108; wb_en never 1.
REQ-036 LDM reg_list=0x4001, base=0x200, ack after 2 wait cycles each, rdata 0xAAAA0000/0xBBBB0000 -> wb R0=0xAAAA0000, R14=0xBBBB0000, each wb_en one cycle after its ack; mem_addr stable across waits.
REQ-037 start with reg_list=0 -> no mem_req; done pulse one cycle later; end_addr=base.
REQ-038 Second start asserted while busy -> ignored; transfer count and addresses match first command only.
REQ-039 reset asserted after first of three LDM acks -> outputs zero same cycle; no further wb_en; new start runs cleanly.
REQ-040 base=0xFFFFFFFC, reg_list=0x0003 -> addresses 0xFFFFFFFC then 0x00000000; end_addr=0x00000004.
